// File: rtl/addsub_pkg.sv
// Shared types and helpers for the digit-serial add/sub unit.
// FSM state, digit count and saturation patterns.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int MAX_W = 1024;

    function automatic int num_digits(int width, int digit);
        return (digit < 1) ? 1 : width / digit;
    endfunction

    // Largest positive signed value of the given width.
    function automatic logic [MAX_W-1:0] sat_max_pat(int width);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < width - 1; i++) begin
            r[i] = 1'b1;
        end
        return r;
    endfunction

    // Most negative signed value of the given width.
    function automatic logic [MAX_W-1:0] sat_min_pat(int width);
        logic [MAX_W-1:0] r;
        r = '0;
        r[width-1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/digit_serial_addsub_rca_digit.sv
// DIGIT-bit combinational ripple-carry slice.
// Also exports the carry into its top bit for overflow detection.
module rca_digit #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    // Ripple the carry through every bit of the slice.
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial add/subtract with optional signed saturation.
// One DIGIT-bit slice per clock, LSB first, valid/ready on both sides.
module digit_serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             carry_in,
    input  logic             subtract_mode,
    input  logic             sat_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int ND = num_digits(WIDTH, DIGIT);
    localparam int CW = (ND > 1) ? $clog2(ND) : 1;
    localparam logic [CW-1:0] LAST = CW'(ND - 1);
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max_pat(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min_pat(WIDTH));

    if (DIGIT < 1) begin : g_bad_digit
        $error("digit_serial_addsub: DIGIT must be >= 1");
    end else if (WIDTH % DIGIT != 0) begin : g_bad_width
        $error("digit_serial_addsub: WIDTH must be a multiple of DIGIT");
    end

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic             sub_q;
    logic             sat_q;
    logic             c_q;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] sl_a;
    logic [DIGIT-1:0] sl_b;
    logic [DIGIT-1:0] sl_sum;
    logic             sl_cout;
    logic             sl_cmsb;
    logic [WIDTH-1:0] full;
    logic             raw_ovf;
    logic [WIDTH-1:0] final_res;

    // Select the current slice and merge its sum into the partial result.
    always_comb begin
        sl_a = a_q[int'(cnt)*DIGIT +: DIGIT];
        sl_b = b_q[int'(cnt)*DIGIT +: DIGIT];
        full = acc;
        full[int'(cnt)*DIGIT +: DIGIT] = sl_sum;
    end

    rca_digit #(
        .DIGIT (DIGIT)
    ) u_slice (
        .a     (sl_a),
        .b     (sl_b),
        .cin   (c_q),
        .sum   (sl_sum),
        .cout  (sl_cout),
        .c_msb (sl_cmsb)
    );

    assign raw_ovf = sl_cmsb ^ sl_cout;

    // Clamp toward the sign shared by both effective operands.
    always_comb begin
        final_res = full;
        if (sat_q && raw_ovf) begin
            final_res = (!a_q[WIDTH-1] && !b_q[WIDTH-1]) ? SAT_MAX : SAT_MIN;
        end
    end

    assign in_ready = (state == IDLE);

    // Control FSM plus the datapath registers it sequences.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            sub_q     <= 1'b0;
            sat_q     <= 1'b0;
            c_q       <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= operand_a;
                        b_q   <= operand_b ^ {WIDTH{subtract_mode}};
                        sub_q <= subtract_mode;
                        sat_q <= sat_mode;
                        c_q   <= carry_in ^ subtract_mode;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= full;
                    c_q <= sl_cout;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        result    <= final_res;
                        carry_out <= sl_cout ^ sub_q;
                        overflow  <= raw_ovf;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Self-checking bench for digit_serial_addsub.
// Random and directed ops against an integer-arithmetic model.
module tb_digit_serial_addsub;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        carry_in;
    logic        subtract_mode;
    logic        sat_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        carry_out;
    logic        overflow;

    logic        n_valid;
    logic [15:0] n_a;
    logic [15:0] n_b;
    logic        n_cin;
    logic        n_sub;
    logic        n_sat;
    logic        n_out_ready;
    logic        o1_ready, o1_valid, o1_co, o1_ov;
    logic [15:0] o1_res;
    logic        o4_ready, o4_valid, o4_co, o4_ov;
    logic [15:0] o4_res;

    int n_cmp;
    int n_fail;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic        sat;
        logic [31:0] r;
        logic        co;
        logic        ov;
    } vec_t;

    digit_serial_addsub #(.WIDTH(32), .DIGIT(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .carry_in      (carry_in),
        .subtract_mode (subtract_mode),
        .sat_mode      (sat_mode),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .carry_out     (carry_out),
        .overflow      (overflow)
    );

    digit_serial_addsub #(.WIDTH(16), .DIGIT(16)) dut16x1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (n_valid),
        .in_ready      (o1_ready),
        .operand_a     (n_a),
        .operand_b     (n_b),
        .carry_in      (n_cin),
        .subtract_mode (n_sub),
        .sat_mode      (n_sat),
        .out_valid     (o1_valid),
        .out_ready     (n_out_ready),
        .result        (o1_res),
        .carry_out     (o1_co),
        .overflow      (o1_ov)
    );

    digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) dut16x4 (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (n_valid),
        .in_ready      (o4_ready),
        .operand_a     (n_a),
        .operand_b     (n_b),
        .carry_in      (n_cin),
        .subtract_mode (n_sub),
        .sat_mode      (n_sat),
        .out_valid     (o4_valid),
        .out_ready     (n_out_ready),
        .result        (o4_res),
        .carry_out     (o4_co),
        .overflow      (o4_ov)
    );

    always #5 clk = ~clk;

    // Reference: {carry/borrow, overflow, result} from integer arithmetic.
    function automatic logic [65:0] model(int w, longint a, longint b,
                                          bit cin, bit sub, bit sat);
        longint lim, half, sa, sb, u, s, r;
        logic   co, ov;
        lim  = longint'(1) << w;
        half = lim / 2;
        sa   = (a >= half) ? a - lim : a;
        sb   = (b >= half) ? b - lim : b;
        u    = sub ? a - b - longint'(cin) : a + b + longint'(cin);
        s    = sub ? sa - sb - longint'(cin) : sa + sb + longint'(cin);
        co   = sub ? (u < 0) : (u >= lim);
        ov   = (s >= half) || (s < -half);
        r    = u & (lim - 1);
        if (sat && ov) r = (s >= half) ? half - 1 : half;
        return {co, ov, 64'(r)};
    endfunction

    function automatic logic [31:0] pick(int w);
        longint lim, v;
        lim = longint'(1) << w;
        case ($urandom_range(0, 5))
            0: v = 0;
            1: v = lim / 2 - 1;
            2: v = lim / 2;
            3: v = lim - 1;
            default: v = longint'($urandom) & (lim - 1);
        endcase
        return 32'(v);
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub, input logic sat,
                          output logic [31:0] res, output logic co,
                          output logic ov, output int lat);
        @(negedge clk);
        operand_a     = a;
        operand_b     = b;
        carry_in      = cin;
        subtract_mode = sub;
        sat_mode      = sat;
        out_ready     = 1'b1;
        in_valid      = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        res = result;
        co  = carry_out;
        ov  = overflow;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        n_cmp++;
        if ({out_valid, carry_out, overflow, result} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got v%b c%b o%b r%h want 0",
                     out_valid, carry_out, overflow, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        vec_t v [10];
        logic [31:0] r;
        logic co, ov;
        int lat;
        v[0] = {32'h00001000, 32'h00002000, 3'b000, 32'h00003000, 2'b00};
        v[1] = {32'h7FFFFFFF, 32'h00000001, 3'b000, 32'h80000000, 2'b01};
        v[2] = {32'h7FFFFFFF, 32'h00000001, 3'b001, 32'h7FFFFFFF, 2'b01};
        v[3] = {32'hFFFFFFFF, 32'h00000001, 3'b000, 32'h00000000, 2'b10};
        v[4] = {32'h00000003, 32'h00000005, 3'b010, 32'hFFFFFFFE, 2'b10};
        v[5] = {32'h00000005, 32'h00000003, 3'b010, 32'h00000002, 2'b00};
        v[6] = {32'h80000000, 32'h00000001, 3'b010, 32'h7FFFFFFF, 2'b01};
        v[7] = {32'h80000000, 32'h00000001, 3'b011, 32'h80000000, 2'b01};
        v[8] = {32'h0000000F, 32'h00000000, 3'b100, 32'h00000010, 2'b00};
        v[9] = {32'h0000000A, 32'h00000003, 3'b110, 32'h00000006, 2'b00};
        for (int i = 0; i < 10; i++) begin
            run_op(v[i].a, v[i].b, v[i].cin, v[i].sub, v[i].sat,
                   r, co, ov, lat);
            n_cmp++;
            if (r !== v[i].r) begin
                n_fail++;
                $display("FAIL dir%0d_result got %h want %h", i, r, v[i].r);
            end
            n_cmp++;
            if (co !== v[i].co) begin
                n_fail++;
                $display("FAIL dir%0d_carry got %b want %b", i, co, v[i].co);
            end
            n_cmp++;
            if (ov !== v[i].ov) begin
                n_fail++;
                $display("FAIL dir%0d_ovf got %b want %b", i, ov, v[i].ov);
            end
            n_cmp++;
            if (lat != 4) begin
                n_fail++;
                $display("FAIL dir%0d_latency got %0d want 4", i, lat);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, r;
        logic cin, sub, sat, co, ov;
        logic [65:0] e;
        int lat;
        for (int i = 0; i < 30; i++) begin
            a   = pick(32);
            b   = pick(32);
            cin = 1'($urandom);
            sub = 1'($urandom);
            sat = 1'($urandom);
            e   = model(32, longint'(a), longint'(b), cin, sub, sat);
            run_op(a, b, cin, sub, sat, r, co, ov, lat);
            n_cmp++;
            if ({co, ov, r} !== {e[65], e[64], e[31:0]} || lat != 4) begin
                n_fail++;
                $display("FAIL rand%0d got c%b o%b r%h lat%0d want c%b o%b r%h lat4",
                         i, co, ov, r, lat, e[65], e[64], e[31:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [65:0] expq [$];
        int          acc [$];
        logic [65:0] e;
        logic [31:0] a, b;
        logic        cin, sub, sat;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 120; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                n_cmp++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra result got %h want none", result);
                end else begin
                    e = expq.pop_front();
                    if ({carry_out, overflow, result} !== {e[65], e[64], e[31:0]}) begin
                        n_fail++;
                        $display("FAIL b2b_result got c%b o%b r%h want c%b o%b r%h",
                                 carry_out, overflow, result,
                                 e[65], e[64], e[31:0]);
                    end
                end
            end
            if (in_ready && acc.size() < 4) begin
                a   = $urandom;
                b   = $urandom;
                cin = 1'($urandom);
                sub = 1'($urandom);
                sat = 1'($urandom);
                operand_a     = a;
                operand_b     = b;
                carry_in      = cin;
                subtract_mode = sub;
                sat_mode      = sat;
                in_valid      = 1'b1;
                expq.push_back(model(32, longint'(a), longint'(b), cin, sub, sat));
                acc.push_back(cyc);
            end else if (acc.size() >= 4) begin
                in_valid = 1'b0;
            end
            if (acc.size() >= 4 && expq.size() == 0) break;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (acc.size() != 4 || expq.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count got acc%0d pend%0d want acc4 pend0",
                     acc.size(), expq.size());
        end
        for (int i = 1; i < acc.size(); i++) begin
            n_cmp++;
            if (acc[i] - acc[i-1] != 6) begin
                n_fail++;
                $display("FAIL b2b_spacing got %0d want 6", acc[i] - acc[i-1]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [65:0] e;
        int seen;
        @(negedge clk);
        operand_a     = 32'h12345678;
        operand_b     = 32'h7F0F0F0F;
        carry_in      = 1'b1;
        subtract_mode = 1'b0;
        sat_mode      = 1'b0;
        out_ready     = 1'b0;
        in_valid      = 1'b1;
        e = model(32, 64'h12345678, 64'h7F0F0F0F, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                seen = 1;
                break;
            end
        end
        n_cmp++;
        if (seen != 1) begin
            n_fail++;
            $display("FAIL bp_done got no out_valid want out_valid");
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            in_valid      = ((k % 2) == 0);
            operand_a     = $urandom;
            operand_b     = $urandom;
            subtract_mode = 1'($urandom);
            @(posedge clk);
            #1;
            n_cmp++;
            if ({out_valid, in_ready, carry_out, overflow, result} !==
                {1'b1, 1'b0, e[65], e[64], e[31:0]}) begin
                n_fail++;
                $display("FAIL bp_hold%0d got v%b rdy%b c%b o%b r%h want v1 rdy0 c%b o%b r%h",
                         k, out_valid, in_ready, carry_out, overflow, result,
                         e[65], e[64], e[31:0]);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release got v%b rdy%b want v0 rdy1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_idle got v%b rdy%b want v0 rdy1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] r;
        logic co, ov;
        int lat;
        run_op(32'h11111111, 32'h22222222, 1'b0, 1'b0, 1'b0, r, co, ov, lat);
        @(negedge clk);
        operand_a     = 32'h0F0F0F0F;
        operand_b     = 32'h01010101;
        carry_in      = 1'b0;
        subtract_mode = 1'b0;
        sat_mode      = 1'b0;
        in_valid      = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, carry_out, overflow, result} !== 35'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_async got v%b c%b o%b r%h rdy%b want all 0 rdy1",
                     out_valid, carry_out, overflow, result, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0, 1'b0, r, co, ov, lat);
        n_cmp++;
        if ({co, ov, r} !== {2'b00, 32'hFFFFFFFF} || lat != 4) begin
            n_fail++;
            $display("FAIL rst_after got c%b o%b r%h lat%0d want c0 o0 rFFFFFFFF lat4",
                     co, ov, r, lat);
        end
    endtask

    task automatic test_narrow();
        logic [31:0] ta, tb;
        logic [65:0] e;
        logic [15:0] r1, r4;
        logic c1, v1, c4, v4;
        int l1, l4;
        n_out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 0) begin
                ta = 32'h0000FFFF;
                tb = 32'h00000000;
                n_cin = 1'b1;
                n_sub = 1'b0;
                n_sat = 1'b0;
            end else begin
                ta = pick(16);
                tb = pick(16);
                n_cin = 1'($urandom);
                n_sub = 1'($urandom);
                n_sat = 1'($urandom);
            end
            n_a = ta[15:0];
            n_b = tb[15:0];
            n_valid = 1'b1;
            e = model(16, longint'(ta), longint'(tb), n_cin, n_sub, n_sat);
            @(posedge clk);
            #1;
            n_valid = 1'b0;
            l1 = -1;
            l4 = -1;
            {r1, c1, v1, r4, c4, v4} = '0;
            for (int k = 1; k <= 20; k++) begin
                @(posedge clk);
                #1;
                if (o1_valid && l1 < 0) begin
                    l1 = k;
                    {r1, c1, v1} = {o1_res, o1_co, o1_ov};
                end
                if (o4_valid && l4 < 0) begin
                    l4 = k;
                    {r4, c4, v4} = {o4_res, o4_co, o4_ov};
                end
                if (l1 >= 0 && l4 >= 0) break;
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if ({c1, v1, r1} !== {e[65], e[64], e[15:0]} || l1 != 1) begin
                n_fail++;
                $display("FAIL w16d16_op%0d got c%b o%b r%h lat%0d want c%b o%b r%h lat1",
                         i, c1, v1, r1, l1, e[65], e[64], e[15:0]);
            end
            n_cmp++;
            if ({c4, v4, r4} !== {e[65], e[64], e[15:0]} || l4 != 4) begin
                n_fail++;
                $display("FAIL w16d4_op%0d got c%b o%b r%h lat%0d want c%b o%b r%h lat4",
                         i, c4, v4, r4, l4, e[65], e[64], e[15:0]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp         = 0;
        n_fail        = 0;
        clk           = 1'b0;
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        operand_a     = '0;
        operand_b     = '0;
        carry_in      = 1'b0;
        subtract_mode = 1'b0;
        sat_mode      = 1'b0;
        out_ready     = 1'b1;
        n_valid       = 1'b0;
        n_a           = '0;
        n_b           = '0;
        n_cin         = 1'b0;
        n_sub         = 1'b0;
        n_sat         = 1'b0;
        n_out_ready   = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
        test_narrow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
